// File: rtl/bias_pkg.sv
// Shared constants and helpers for the bias_bank_stream bias stage.
package bias_pkg;

    localparam int BIAS_DATA_W  = 18;
    localparam int BIAS_N_LANES = 16;

    localparam logic signed [BIAS_DATA_W-1:0] SAT_MAX = {1'b0, {(BIAS_DATA_W-1){1'b1}}};
    localparam logic signed [BIAS_DATA_W-1:0] SAT_MIN = {1'b1, {(BIAS_DATA_W-1){1'b0}}};

    // Lane i of a packed vector lives at bits [DATA_W*(i+1)-1 : DATA_W*i].
    function automatic logic [BIAS_DATA_W-1:0] lane_slice(
        input logic [BIAS_N_LANES*BIAS_DATA_W-1:0] vec,
        input int                                  lane
    );
        return vec[lane*BIAS_DATA_W +: BIAS_DATA_W];
    endfunction

endpackage

// File: rtl/bias_bank_stream_if.sv
// Config port plus input/output valid/ready streams of the bias stage.
interface bias_bank_stream_if #(
    parameter int N_LANES = 16,
    parameter int DATA_W  = 18,
    parameter int GRP_W   = 2
) ();

    logic                       cfg_we;
    logic [GRP_W-1:0]           cfg_grp;
    logic [N_LANES*DATA_W-1:0]  cfg_data;

    logic                       in_valid;
    logic                       in_ready;
    logic [N_LANES*DATA_W-1:0]  in_data;
    logic                       in_last;

    logic                       out_valid;
    logic                       out_ready;
    logic [N_LANES*DATA_W-1:0]  out_data;
    logic                       out_last;
    logic [GRP_W-1:0]           out_grp;

    modport master (
        output cfg_we, cfg_grp, cfg_data,
        output in_valid, in_data, in_last,
        input  in_ready,
        input  out_valid, out_data, out_last, out_grp,
        output out_ready
    );

    modport slave (
        input  cfg_we, cfg_grp, cfg_data,
        input  in_valid, in_data, in_last,
        output in_ready,
        output out_valid, out_data, out_last, out_grp,
        input  out_ready
    );

endinterface

// File: rtl/bias_sat_add.sv
// One lane: sign-extended accumulator + bias with clamp to the DATA_W range.
// Optional build macro BIAS_BANK_RELU_EN forces negative results to zero after the clamp.
module bias_sat_add
    import bias_pkg::*;
#(
    parameter int DATA_W = BIAS_DATA_W
) (
    input  logic signed [DATA_W-1:0] acc,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [DATA_W-1:0] res,
    output logic                     sat
);

    localparam logic signed [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W:0] sum;

    // Overflow shows as the two top bits of the widened sum disagreeing.
    function automatic logic signed [DATA_W-1:0] clamp(input logic signed [DATA_W:0] s);
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? MINV : MAXV;
        end
        return s[DATA_W-1:0];
    endfunction

`ifdef BIAS_BANK_RELU_EN
    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? '0 : v;
    endfunction
`endif

    always_comb begin
        sum = {acc[DATA_W-1], acc} + {bias[DATA_W-1], bias};
        sat = sum[DATA_W] ^ sum[DATA_W-1];
`ifdef BIAS_BANK_RELU_EN
        res = relu(clamp(sum));
`else
        res = clamp(sum);
`endif
    end

endmodule

// File: rtl/bias_bank_stream.sv
// Runtime-loadable bias bank added per channel group to accumulator beats, with one output register.
// Optional build macro BIAS_BANK_RELU_EN (handled per lane in bias_sat_add).
module bias_bank_stream
    import bias_pkg::*;
#(
    parameter int N_LANES    = BIAS_N_LANES,
    parameter int DATA_W     = BIAS_DATA_W,
    parameter int NUM_GROUPS = 4,
    parameter int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    bias_bank_stream_if.slave  bus,
    output logic               sat_seen
);

    localparam int               BUS_W    = N_LANES * DATA_W;
    localparam logic [GRP_W:0]   NG_EXT   = (GRP_W+1)'(NUM_GROUPS);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_GROUPS - 1);

    logic [BUS_W-1:0]   bank [NUM_GROUPS];
    logic [GRP_W-1:0]   grp;

    logic               ready_p0;
    logic               accept_p0;
    logic [BUS_W-1:0]   row_p0;
    logic [BUS_W-1:0]   data_p0;
    logic [N_LANES-1:0] sat_p0;

    logic               vld_p1;
    logic [BUS_W-1:0]   data_p1;
    logic               last_p1;
    logic [GRP_W-1:0]   grp_p1;

    function automatic logic [GRP_W-1:0] grp_next(input logic [GRP_W-1:0] g);
        return (g == GRP_LAST) ? '0 : g + 1'b1;
    endfunction

    // ---- stage p0: handshake, bank read, per-lane add/clamp ----
    assign ready_p0  = !vld_p1 || bus.out_ready;
    assign accept_p0 = bus.in_valid && ready_p0;
    assign row_p0    = bank[grp];

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        bias_sat_add #(
            .DATA_W (DATA_W)
        ) u_add (
            .acc  (bus.in_data[i*DATA_W +: DATA_W]),
            .bias (row_p0[i*DATA_W +: DATA_W]),
            .res  (data_p0[i*DATA_W +: DATA_W]),
            .sat  (sat_p0[i])
        );
    end

    // Reads above see the pre-write row, so a same-edge write only affects later beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                bank[g] <= '0;
            end
        end else if (bus.cfg_we && ({1'b0, bus.cfg_grp} < NG_EXT)) begin
            bank[bus.cfg_grp] <= bus.cfg_data;
        end
    end

    // ---- stage p1: output register and group counter ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            last_p1  <= 1'b0;
            grp_p1   <= '0;
            grp      <= '0;
            sat_seen <= 1'b0;
        end else if (accept_p0) begin
            vld_p1  <= 1'b1;
            data_p1 <= data_p0;
            last_p1 <= bus.in_last;
            grp_p1  <= grp;
            if (bus.in_last) begin
                grp <= grp_next(grp);
            end
            if (|sat_p0) begin
                sat_seen <= 1'b1;
            end
        end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.in_ready  = ready_p0;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_last  = last_p1;
    assign bus.out_grp   = grp_p1;

endmodule

// File: tb/tb_bias_bank_stream.sv
// Directed bench for bias_bank_stream; expectations follow BIAS_BANK_RELU_EN when defined.
module tb_bias_bank_stream;
    import bias_pkg::*;

    localparam int NL = 16;
    localparam int DW = 18;
    localparam int NG = 4;
    localparam int GW = 2;
    localparam int BW = NL * DW;
    localparam int NB = 8;

    logic clk = 1'b0;
    logic rst;
    logic sat_seen;

    bias_bank_stream_if #(.N_LANES(NL), .DATA_W(DW), .GRP_W(GW)) bus ();

    bias_bank_stream #(
        .N_LANES    (NL),
        .DATA_W     (DW),
        .NUM_GROUPS (NG),
        .GRP_W      (GW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sat_seen (sat_seen)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] fill(input logic [DW-1:0] v);
        logic [BW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] rl(input logic [DW-1:0] v);
`ifdef BIAS_BANK_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [BW-1:0] pat(input int k);
        logic [BW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*DW +: DW] = DW'(k*16 + i + 1);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.cfg_we = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [GW-1:0] g, input logic [BW-1:0] d);
        @(negedge clk);
        bus.cfg_we = 1'b1;
        bus.cfg_grp = g;
        bus.cfg_data = d;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    logic [BW-1:0] exp_row [4];
    logic [BW-1:0] q_data [$];
    logic [GW-1:0] q_grp [$];
    logic [BW-1:0] a, b;
    int sent, got, j;

    initial begin
        rst = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_grp = '0; bus.cfg_data = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_grp", bus.out_grp, 0);
        chk("rst_sat", sat_seen, 0);
        chk("rst_ready", bus.in_ready, 1);
        rst = 1'b0;

        // Four groups of three beats, lanes = 5, then one wrap beat.
        cfg_write(2'd0, fill(18'h00100));
        cfg_write(2'd1, fill(18'h3FF00));
        cfg_write(2'd2, fill(18'h00000));
        cfg_write(2'd3, fill(18'h1FFFF));
        exp_row[0] = fill(18'h00105);
        exp_row[1] = fill(rl(18'h3FF05));
        exp_row[2] = fill(18'h00005);
        exp_row[3] = fill(18'h1FFFF);
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (k > 0) begin
                j = k - 1;
                chk($sformatf("s%0d_vld", j), bus.out_valid, 1);
                chk($sformatf("s%0d_data", j), bus.out_data, exp_row[(j/3)%4]);
                chk($sformatf("s%0d_grp", j), bus.out_grp, BW'((j/3)%4));
                chk($sformatf("s%0d_last", j), bus.out_last, BW'(j%3 == 2 && j < 12));
                chk($sformatf("s%0d_sat", j), sat_seen, BW'(j >= 9));
            end
            if (k < 13) begin
                bus.in_valid = 1'b1;
                bus.in_data = fill(18'd5);
                bus.in_last = (k%3 == 2) && (k < 12);
            end else begin
                bus.in_valid = 1'b0;
            end
        end

        // Saturation corners, lane-specific.
        do_reset();
        b = '0;
        b[0*DW +: DW] = 18'h00001;
        b[1*DW +: DW] = 18'h3FFFF;
        b[2*DW +: DW] = 18'h00001;
        cfg_write(2'd0, b);
        @(negedge clk);
        a = '0;
        a[2*DW +: DW] = 18'h1FFFE;
        bus.in_valid = 1'b1; bus.in_data = a; bus.in_last = 1'b0;
        @(negedge clk);
        chk("c1_l0", lane_slice(bus.out_data, 0), 18'h00001);
        chk("c1_l1", lane_slice(bus.out_data, 1), rl(18'h3FFFF));
        chk("c1_l2", lane_slice(bus.out_data, 2), 18'h1FFFF);
        chk("c1_l3", lane_slice(bus.out_data, 3), 18'h00000);
        chk("c1_nosat", sat_seen, 0);
        a = '0;
        a[0*DW +: DW] = 18'h1FFFF;
        a[1*DW +: DW] = 18'h20000;
        bus.in_data = a;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("c2_l0", lane_slice(bus.out_data, 0), 18'h1FFFF);
        chk("c2_l1", lane_slice(bus.out_data, 1), rl(18'h20000));
        chk("c2_l2", lane_slice(bus.out_data, 2), 18'h00001);
        chk("c2_sat", sat_seen, 1);

        // Backpressure with a scoreboard; bank is zero so output equals input.
        do_reset();
        sent = 0; got = 0;
        for (int c = 0; c < 60 && got < NB; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 1 && c <= 5);
            if (sent < NB) begin
                bus.in_valid = 1'b1; bus.in_data = pat(sent); bus.in_last = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (c >= 1 && c <= 5) begin
                chk($sformatf("bp_stall%0d_rdy", c), bus.in_ready, 0);
                chk($sformatf("bp_stall%0d_vld", c), bus.out_valid, 1);
                chk($sformatf("bp_stall%0d_data", c), bus.out_data, pat(0));
                chk($sformatf("bp_stall%0d_grp", c), bus.out_grp, 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q_data.size() == 0) begin
                    chk("bp_extra", 1, 0);
                end else begin
                    chk($sformatf("bp%0d_data", got), bus.out_data, q_data.pop_front());
                    chk($sformatf("bp%0d_grp", got), bus.out_grp, q_grp.pop_front());
                    got++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q_data.push_back(pat(sent));
                q_grp.push_back(GW'(sent % NG));
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        chk("bp_count", got, NB);
        chk("bp_left", q_data.size(), 0);
        repeat (2) @(negedge clk);
        chk("bp_drained", bus.out_valid, 0);

        // Same-edge write and beat: old row first, new row after.
        do_reset();
        cfg_write(2'd0, fill(18'h00100));
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_grp = 2'd0; bus.cfg_data = fill(18'h00010);
        bus.in_valid = 1'b1; bus.in_data = '0; bus.in_last = 1'b0;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        chk("wr_old", bus.out_data, fill(18'h00100));
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("wr_new", bus.out_data, fill(18'h00010));

        // Mid-stream reset with a held output and sat_seen set.
        cfg_write(2'd1, fill(18'h00020));
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = fill(18'h00001); bus.in_last = 1'b1;
        @(negedge clk);
        chk("mr_a_data", bus.out_data, fill(18'h00011));
        bus.in_data = fill(18'h1FFFF); bus.in_last = 1'b0;
        @(negedge clk);
        chk("mr_b_data", bus.out_data, fill(18'h1FFFF));
        chk("mr_b_grp", bus.out_grp, 1);
        chk("mr_b_sat", sat_seen, 1);
        rst = 1'b1;
        bus.in_data = fill(18'h00007);
        @(negedge clk);
        rst = 1'b0;
        chk("mr_vld", bus.out_valid, 0);
        chk("mr_sat", sat_seen, 0);
        chk("mr_data", bus.out_data, 0);
        bus.in_data = fill(18'h00005);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mr_next_vld", bus.out_valid, 1);
        chk("mr_next_data", bus.out_data, fill(18'h00005));
        chk("mr_next_grp", bus.out_grp, 0);

        // Negative result: zero under ReLU, passed through otherwise.
        do_reset();
        cfg_write(2'd0, fill(18'h3FF00));
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = fill(18'd5); bus.in_last = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("relu_data", bus.out_data, fill(rl(18'h3FF05)));
        chk("relu_sat", sat_seen, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
